rsa_multi_wrapper: RTL and testbench

RSA_MULTI_WRAPPER -- requirements
Module: rsa_multi_wrapper

---
 rtl/rsa_multi_wrapper.sv | 161 ++++++++++++++++
 tb/tb_rsa_multi_wrapper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_multi_wrapper.sv
// Arm/FPGA command wrapper around N_CH RSA exponentiation cores: operand loading,
// non-blocking start, result collection and a sticky error/status word.
module rsa_multi_wrapper #(
    parameter int OP_W    = 512,
    parameter int TX_SIZE = 1024,
    parameter int N_CH    = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            arm_to_fpga_cmd,
    input  logic                   arm_to_fpga_cmd_valid,
    output logic                   fpga_to_arm_done,
    input  logic                   fpga_to_arm_done_read,
    input  logic                   arm_to_fpga_data_valid,
    output logic                   arm_to_fpga_data_ready,
    input  logic [TX_SIZE-1:0]     arm_to_fpga_data,
    output logic                   fpga_to_arm_data_valid,
    input  logic                   fpga_to_arm_data_ready,
    output logic [TX_SIZE-1:0]     fpga_to_arm_data,
    output logic [N_CH-1:0]        core_start,
    output logic [N_CH-1:0]        core_mode,
    output logic [N_CH*OP_W-1:0]   core_modulus,
    output logic [N_CH*OP_W-1:0]   core_rmodm,
    output logic [N_CH*OP_W-1:0]   core_rsq,
    output logic [N_CH*OP_W-1:0]   core_exp,
    output logic [N_CH*OP_W-1:0]   core_x,
    input  logic [N_CH-1:0]        core_done,
    input  logic [N_CH*OP_W-1:0]   core_result,
    output logic [3:0]             leds
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RX = 2'd1, S_TX = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [4:0] NCH = 5'(N_CH);

    state_t                     state;
    logic [2:0]                 op_q;
    logic [3:0]                 ch_q;
    logic [N_CH-1:0][OP_W-1:0]  modulus_q, rmodm_q, rsq_q, exp_q, x_q, result_q;
    logic [N_CH-1:0]            busy, rdy;
    logic                       err;
    logic [TX_SIZE-1:0]         tx_data;

    logic [2:0] opcode;
    logic       mode;
    logic [3:0] ch;
    logic       bad_cmd;

    assign opcode  = arm_to_fpga_cmd[2:0];
    assign mode    = arm_to_fpga_cmd[3];
    assign ch      = arm_to_fpga_cmd[7:4];
    assign bad_cmd = (opcode >= 3'd6) || ({1'b0, ch} >= NCH);

    assign arm_to_fpga_data_ready = (state == S_RX);
    assign fpga_to_arm_data_valid = (state == S_TX);
    assign fpga_to_arm_done       = (state == S_DONE);
    assign fpga_to_arm_data       = tx_data;
    assign leds                   = {err, |busy, state[1:0]};

    assign core_modulus = modulus_q;
    assign core_rmodm   = rmodm_q;
    assign core_rsq     = rsq_q;
    assign core_exp     = exp_q;
    assign core_x       = x_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            op_q       <= '0;
            ch_q       <= '0;
            modulus_q  <= '0;
            rmodm_q    <= '0;
            rsq_q      <= '0;
            exp_q      <= '0;
            x_q        <= '0;
            result_q   <= '0;
            busy       <= '0;
            rdy        <= '0;
            err        <= 1'b0;
            tx_data    <= '0;
            core_start <= '0;
            core_mode  <= '0;
        end else begin
            core_start <= '0;
            // Completion first so that a same-cycle START re-arms busy.
            for (int c = 0; c < N_CH; c++) begin
                if (core_done[c]) begin
                    result_q[c] <= core_result[c*OP_W +: OP_W];
                    busy[c]     <= 1'b0;
                    rdy[c]      <= 1'b1;
                end
            end
            case (state)
                S_IDLE: if (arm_to_fpga_cmd_valid) begin
                    op_q <= opcode;
                    ch_q <= ch;
                    if (bad_cmd) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        case (opcode)
                            3'd3: begin
                                state <= S_DONE;
                                for (int c = 0; c < N_CH; c++) begin
                                    if (4'(c) == ch) begin
                                        if (busy[c] && !core_done[c]) err <= 1'b1;
                                        else begin
                                            core_start[c] <= 1'b1;
                                            busy[c]       <= 1'b1;
                                            core_mode[c]  <= mode;
                                        end
                                    end
                                end
                            end
                            3'd4: begin
                                state   <= S_TX;
                                tx_data <= '0;
                                for (int c = 0; c < N_CH; c++)
                                    if (4'(c) == ch) tx_data <= {{OP_W{1'b0}}, result_q[c]};
                            end
                            3'd5: begin
                                state                   <= S_TX;
                                tx_data                 <= '0;
                                tx_data[N_CH-1:0]       <= busy;
                                tx_data[2*N_CH-1:N_CH]  <= rdy;
                                tx_data[TX_SIZE-1]      <= err;
                            end
                            default: state <= S_RX;
                        endcase
                    end
                end
                S_RX: if (arm_to_fpga_data_valid) begin
                    state <= S_DONE;
                    for (int c = 0; c < N_CH; c++) begin
                        if (4'(c) == ch_q) begin
                            if (busy[c] && !core_done[c]) err <= 1'b1;
                            else if (op_q == 3'd0) begin
                                modulus_q[c] <= arm_to_fpga_data[OP_W-1:0];
                                rmodm_q[c]   <= arm_to_fpga_data[TX_SIZE-1:OP_W];
                            end else if (op_q == 3'd1) begin
                                rsq_q[c] <= arm_to_fpga_data[OP_W-1:0];
                                x_q[c]   <= arm_to_fpga_data[TX_SIZE-1:OP_W];
                            end else begin
                                exp_q[c] <= arm_to_fpga_data[OP_W-1:0];
                            end
                        end
                    end
                end
                S_TX: if (fpga_to_arm_data_ready) begin
                    state <= S_DONE;
                    if (op_q == 3'd5) err <= 1'b0;
                    else begin
                        for (int c = 0; c < N_CH; c++)
                            if (4'(c) == ch_q) rdy[c] <= core_done[c];
                    end
                end
                S_DONE: if (fpga_to_arm_done_read) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_multi_wrapper.sv
// Directed bench for rsa_multi_wrapper: loads, starts, completions, READ/STATUS,
// error paths and reset mid-transfer, all against hand-computed values.
module tb_rsa_multi_wrapper;
    localparam int OP_W = 512;
    localparam int TX   = 1024;
    localparam int NC   = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [31:0]     cmd;
    logic            cmd_valid;
    logic            done;
    logic            done_read;
    logic            in_valid;
    logic            in_ready;
    logic [TX-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [TX-1:0]   out_data;
    logic [NC-1:0]   core_start, core_mode, core_done;
    logic [NC*OP_W-1:0] core_modulus, core_rmodm, core_rsq, core_exp, core_x, core_result;
    logic [3:0]      leds;

    int total = 0;
    int bad   = 0;
    logic [TX-1:0] rd;

    rsa_multi_wrapper #(.OP_W(OP_W), .TX_SIZE(TX), .N_CH(NC)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .fpga_to_arm_done(done), .fpga_to_arm_done_read(done_read),
        .arm_to_fpga_data_valid(in_valid), .arm_to_fpga_data_ready(in_ready),
        .arm_to_fpga_data(in_data),
        .fpga_to_arm_data_valid(out_valid), .fpga_to_arm_data_ready(out_ready),
        .fpga_to_arm_data(out_data),
        .core_start(core_start), .core_mode(core_mode),
        .core_modulus(core_modulus), .core_rmodm(core_rmodm), .core_rsq(core_rsq),
        .core_exp(core_exp), .core_x(core_x),
        .core_done(core_done), .core_result(core_result),
        .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TX-1:0] got, input logic [TX-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h..%0h exp=%0h..%0h", tag,
                     got[TX-1:TX-64], got[127:0], exp[TX-1:TX-64], exp[127:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic m, input logic [3:0] c);
        cmd       = {24'b0, c, m, op};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ack(input string tag);
        chk({tag, "_done"}, TX'(done), TX'(1));
        done_read = 1'b1;
        tick();
        done_read = 1'b0;
        chk({tag, "_done_fall"}, TX'(done), TX'(0));
    endtask

    task automatic load(input string tag, input logic [2:0] op, input logic [3:0] c,
                        input logic [TX-1:0] d);
        send_cmd(op, 1'b0, c);
        chk({tag, "_ready"}, TX'(in_ready), TX'(1));
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_ready_fall"}, TX'(in_ready), TX'(0));
        ack(tag);
    endtask

    task automatic xfer(input string tag, input logic [2:0] op, input logic [3:0] c,
                        output logic [TX-1:0] r);
        send_cmd(op, 1'b0, c);
        chk({tag, "_valid"}, TX'(out_valid), TX'(1));
        r         = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ack(tag);
    endtask

    task automatic start(input string tag, input logic m, input logic [3:0] c,
                         input logic [NC-1:0] exp_pulse);
        send_cmd(3'd3, m, c);
        chk({tag, "_pulse"}, TX'(core_start), TX'(exp_pulse));
        ack(tag);
        chk({tag, "_pulse_end"}, TX'(core_start), TX'(0));
    endtask

    task automatic finish_core(input int c, input logic [OP_W-1:0] v);
        core_result[c*OP_W +: OP_W] = v;
        core_done[c] = 1'b1;
        tick();
        core_done = '0;
    endtask

    initial begin
        resetn = 1'b0; cmd = '0; cmd_valid = 1'b0; done_read = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_done = '0; core_result = '0;
        tick(); tick();
        chk("rst_done", TX'(done), TX'(0));
        chk("rst_ready", TX'(in_ready), TX'(0));
        chk("rst_valid", TX'(out_valid), TX'(0));
        chk("rst_data", out_data, '0);
        chk("rst_leds", TX'(leds), TX'(0));
        chk("rst_start", TX'(core_start), TX'(0));
        resetn = 1'b1;
        tick();

        // Operand loads
        load("loada0", 3'd0, 4'd0, {512'h5, 512'hB});
        chk("mod0", TX'(core_modulus[511:0]), TX'(512'hB));
        chk("rmodm0", TX'(core_rmodm[511:0]), TX'(512'h5));
        load("loadb1", 3'd1, 4'd1, {512'h22, 512'h11});
        chk("rsq1", TX'(core_rsq[1023:512]), TX'(512'h11));
        chk("x1", TX'(core_x[1023:512]), TX'(512'h22));
        load("loade1", 3'd2, 4'd1, {512'hFFFF, 512'h10001});
        chk("exp1", TX'(core_exp[1023:512]), TX'(512'h10001));

        // Two channels started back to back
        start("start0", 1'b0, 4'd0, 2'b01);
        start("start1", 1'b1, 4'd1, 2'b10);
        chk("mode", TX'(core_mode), TX'(2'b10));
        xfer("stat1", 3'd5, 4'd0, rd);
        chk("stat1_word", rd, TX'(4'b0011));

        // Completion on channel 1, then READ clears rdy
        finish_core(1, 512'h1234);
        xfer("stat2", 3'd5, 4'd0, rd);
        chk("stat2_word", rd, TX'(4'b1001));
        xfer("read1", 3'd4, 4'd1, rd);
        chk("read1_word", rd, TX'(512'h1234));
        xfer("stat3", 3'd5, 4'd0, rd);
        chk("stat3_word", rd, TX'(4'b0001));

        // Error paths: busy START, busy LOAD, bad channel, illegal opcode
        start("start_busy", 1'b0, 4'd0, 2'b00);
        load("load_busy", 3'd0, 4'd0, {512'h7, 512'h9});
        chk("mod0_kept", TX'(core_modulus[511:0]), TX'(512'hB));
        send_cmd(3'd3, 1'b0, 4'd15);
        chk("badch_pulse", TX'(core_start), TX'(0));
        chk("badch_leds", TX'(leds), TX'(4'hF));
        ack("badch");
        send_cmd(3'd6, 1'b0, 4'd0);
        ack("illegal");
        xfer("stat4", 3'd5, 4'd0, rd);
        chk("stat4_word", rd, {1'b1, 1019'b0, 4'b0001});
        xfer("stat5", 3'd5, 4'd0, rd);
        chk("stat5_word", rd, TX'(4'b0001));

        // START and completion on channel 0 in the same cycle
        core_result[511:0] = 512'hABC;
        core_done[0] = 1'b1;
        send_cmd(3'd3, 1'b1, 4'd0);
        core_done = '0;
        chk("same_pulse", TX'(core_start), TX'(2'b01));
        ack("same");
        chk("same_mode", TX'(core_mode), TX'(2'b11));
        xfer("stat6", 3'd5, 4'd0, rd);
        chk("stat6_word", rd, TX'(4'b0101));
        xfer("read0", 3'd4, 4'd0, rd);
        chk("read0_word", rd, TX'(512'hABC));

        // Reset while parked in TX with channel 0 busy
        send_cmd(3'd5, 1'b0, 4'd0);
        chk("tx_valid", TX'(out_valid), TX'(1));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst2_valid", TX'(out_valid), TX'(0));
        chk("rst2_done", TX'(done), TX'(0));
        chk("rst2_leds", TX'(leds), TX'(0));
        chk("rst2_data", out_data, '0);
        chk("rst2_mode", TX'(core_mode), TX'(0));
        chk("rst2_mod", TX'(core_modulus), TX'(0));
        xfer("stat7", 3'd5, 4'd0, rd);
        chk("stat7_word", rd, TX'(0));
        finish_core(0, 512'h77);
        xfer("stat8", 3'd5, 4'd0, rd);
        chk("stat8_word", rd, TX'(4'b0100));
        xfer("read2", 3'd4, 4'd0, rd);
        chk("read2_word", rd, TX'(512'h77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
